// File: rtl/vecmac_controller_pkg.sv
// Shared definitions for the sum-of-squares controller: parameter defaults
// and the FSM state encoding.
package vecmac_controller_pkg;

    localparam int WORD_SIZE_DEFAULT = 24;
    localparam int ADDR_SIZE_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vecmac_controller.sv
// Sequencer for one sum-of-squares pass: clears the accumulator, walks len
// element addresses (stalling on hold), then drains the 2-stage enable pipe.
module vecmac_controller
    import vecmac_controller_pkg::*;
#(
    parameter int word_size = WORD_SIZE_DEFAULT,
    parameter int addr_size = ADDR_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] base_addr,
    input  logic [addr_size:0]   len,
    input  logic                 hold,
    output logic [addr_size-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 Store_D,
    output logic                 E_Square,
    output logic                 E_Sum,
    output logic                 acc_clr,
    output logic                 busy,
    output logic                 done
);

    // word_size only matters to the paired datapath; it is range-checked here.
    generate
        if (word_size < 1 || addr_size < 1) begin : g_param_check
            $error("vecmac_controller: word_size and addr_size must be positive");
        end
    endgenerate

    localparam logic [addr_size:0]   COUNT_ZERO = '0;
    localparam logic [addr_size:0]   COUNT_ONE  = {{addr_size{1'b0}}, 1'b1};
    localparam logic [addr_size-1:0] ADDR_ONE   = {{(addr_size-1){1'b0}}, 1'b1};

    state_t                 state_reg;
    state_t                 state_next;
    logic [addr_size-1:0]   addr_reg;
    logic [addr_size-1:0]   last_addr_reg;
    logic [addr_size:0]     count_reg;
    logic [1:0]             delay_reg;
    logic                   issue;

    assign issue = (state_reg == ST_FETCH) && !hold;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address/count registers and the Store_D -> E_Square -> E_Sum delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg      <= '0;
            last_addr_reg <= '0;
            count_reg     <= '0;
            delay_reg     <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                addr_reg  <= base_addr;
                count_reg <= len;
            end else if (issue) begin
                addr_reg      <= addr_reg + ADDR_ONE;
                count_reg     <= count_reg - COUNT_ONE;
                last_addr_reg <= addr_reg;
            end
            delay_reg <= {delay_reg[0], issue};
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = (count_reg != COUNT_ZERO) ? ST_FETCH : ST_DONE;
            ST_FETCH: if (issue && count_reg == COUNT_ONE) state_next = ST_DRAIN;
            // Leave once the final issue has moved past the square stage.
            ST_DRAIN: if (!delay_reg[0]) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, even on the first reset cycle.
    always_comb begin
        mem_addr = '0;
        mem_rd   = 1'b0;
        Store_D  = 1'b0;
        E_Square = 1'b0;
        E_Sum    = 1'b0;
        acc_clr  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (!rst) begin
            mem_addr = issue ? addr_reg : last_addr_reg;
            mem_rd   = issue;
            Store_D  = issue;
            E_Square = delay_reg[0];
            E_Sum    = delay_reg[1];
            acc_clr  = (state_reg == ST_CLEAR);
            busy     = (state_reg != ST_IDLE);
            done     = (state_reg == ST_DONE);
        end
    end

endmodule
